// File: rtl/fpu_pkg.sv
// Shared encodings for the FPU scheduler: op codes, FSM states, requester ids.
package fpu_pkg;

  localparam logic [1:0] FPU_ADD = 2'b00;
  localparam logic [1:0] FPU_SUB = 2'b01;
  localparam logic [1:0] FPU_MUL = 2'b10;
  localparam logic [1:0] FPU_DIV = 2'b11;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Two-requester round-robin grant; i_rr_ptr names the winner of a tie.
module fpu_rr_arbiter (
  input  logic [1:0] i_valid,
  input  logic       i_rr_ptr,
  output logic       o_grant,
  output logic       o_any_valid
);

  assign o_any_valid = |i_valid;
  assign o_grant     = (i_valid == 2'b11) ? i_rr_ptr : i_valid[1];

endmodule

// File: rtl/fpu_scheduler.sv
// Shares one combinational FPU between the core pipe and the aux port.
// Optional sticky flag tracking is enabled with FPU_STICKY_FLAGS_EN.
module fpu_scheduler
  import fpu_pkg::*;
#(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [3:0]  req_op,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_overflow,
  output logic        resp_underflow,
  input  logic [1:0]  sticky_clr,
  output logic [1:0]  sticky_ovf,
  output logic [1:0]  sticky_unf,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  input  logic [31:0] fpu_result,
  input  logic        fpu_overflow,
  input  logic        fpu_underflow
);

  localparam int MAX_LAT = max3(ADD_LAT, MUL_LAT, DIV_LAT);
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_owner, r_rr_ptr;
  logic [31:0]   r_fpu_a, r_fpu_b, r_result;
  logic [1:0]    r_fpu_op, r_resp_valid;
  logic          r_ovf, r_unf;
  logic          w_grant, w_any_valid, w_accept, w_capture, w_done;
  logic [1:0]    w_ready;

  function automatic logic [CW-1:0] lat_m1(input logic [1:0] op);
    int l;
    case (op)
      FPU_MUL: l = MUL_LAT;
      FPU_DIV: l = DIV_LAT;
      default: l = ADD_LAT;
    endcase
    return CW'(l - 1);
  endfunction

  fpu_rr_arbiter u_arb (
    .i_valid     (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_any_valid (w_any_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (w_any_valid) begin
        w_ready[w_grant] = 1'b1;
        w_state_nxt      = EXEC;
      end
      EXEC: if (r_cnt == '0) begin
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      // Handshake edge returns to IDLE only; a new accept needs the next cycle.
      RESP: if (resp_ready[r_owner]) begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = |w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_owner      <= REQ_CORE;
      r_rr_ptr     <= REQ_CORE;
      r_fpu_a      <= '0;
      r_fpu_b      <= '0;
      r_fpu_op     <= '0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_resp_valid <= '0;
    end else begin
      if (w_accept) begin
        r_fpu_a  <= w_grant ? req_a[63:32] : req_a[31:0];
        r_fpu_b  <= w_grant ? req_b[63:32] : req_b[31:0];
        r_fpu_op <= w_grant ? req_op[3:2]  : req_op[1:0];
        r_cnt    <= lat_m1(w_grant ? req_op[3:2] : req_op[1:0]);
        r_owner  <= w_grant;
        r_rr_ptr <= ~w_grant;
      end else if (r_state == EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_result     <= fpu_result;
        r_ovf        <= fpu_overflow;
        r_unf        <= fpu_underflow;
        r_resp_valid <= r_owner ? 2'b10 : 2'b01;
      end
      if (w_done) r_resp_valid <= '0;
    end
  end

  assign req_ready      = w_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_result    = r_result;
  assign resp_overflow  = r_ovf;
  assign resp_underflow = r_unf;
  assign fpu_a          = r_fpu_a;
  assign fpu_b          = r_fpu_b;
  assign fpu_op         = r_fpu_op;

`ifdef FPU_STICKY_FLAGS_EN
  logic [1:0] r_sovf, r_sunf, w_own;

  assign w_own = r_owner ? 2'b10 : 2'b01;

  // Clear is applied first so a same-cycle capture still sets the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sovf <= '0;
      r_sunf <= '0;
    end else begin
      r_sovf <= (r_sovf & ~sticky_clr) | ({2{w_capture & fpu_overflow}}  & w_own);
      r_sunf <= (r_sunf & ~sticky_clr) | ({2{w_capture & fpu_underflow}} & w_own);
    end
  end

  assign sticky_ovf = r_sovf;
  assign sticky_unf = r_sunf;
`else
  logic w_unused_sticky_clr;
  assign w_unused_sticky_clr = ^sticky_clr;
  assign sticky_ovf = '0;
  assign sticky_unf = '0;
`endif

endmodule
